// File: rtl/output_lock_arbiter.sv
// output_lock_arbiter: round-robin switch scheduler for one router output port.
// It locks the port to one requester from the head flit to the tail flit, and
// it grants only when downstream credits are available.
// Latency: zero-cycle arbitration. grants_o is combinational from the current state and the inputs.
// Backpressure: grants_o stays zero while credit_count_o==0. A credit returned at zero permits a grant on the next cycle.
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   requests_i, req_tail_i  per-requester flit-ready and tail markers
//   credit_return_i         one downstream slot freed this cycle
//   grants_o                one-hot or zero transfer grant
//   locked_o, owner_o       wormhole lock flag and lock holder
//   credit_count_o          current downstream credits
// Optional macro ARB_CREDIT_CHECK_EN adds credit_err_o. This output is a sticky flag for credit overflow.
module output_lock_arbiter #(
    parameter int NUM_REQS     = 4,
    parameter int CREDIT_DEPTH = 4,
    localparam int IDX_W = $clog2(NUM_REQS),
    localparam int CNT_W = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [NUM_REQS-1:0] requests_i,
    input  logic [NUM_REQS-1:0] req_tail_i,
    input  logic                credit_return_i,
    output logic [NUM_REQS-1:0] grants_o,
    output logic                locked_o,
    output logic [IDX_W-1:0]    owner_o,
    output logic [CNT_W-1:0]    credit_count_o
`ifdef ARB_CREDIT_CHECK_EN
    ,
    output logic                credit_err_o
`endif
);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDIT_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQS - 1);

    state_t           state_q;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [CNT_W-1:0] credit_q;

    logic             scan_hit;
    logic [IDX_W-1:0] scan_win;
    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] next_ptr;
    logic             fire;
    logic             tail_fire;

    // Scan upward from rr_ptr_q and wrap around. The first requester found wins.
    always_comb begin
        int               pos;
        logic [IDX_W-1:0] idx;
        scan_hit = 1'b0;
        scan_win = '0;
        pos      = 0;
        idx      = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            pos = (int'(rr_ptr_q) + i) % NUM_REQS;
            idx = IDX_W'(pos);
            if (!scan_hit && requests_i[idx]) begin
                scan_hit = 1'b1;
                scan_win = idx;
            end
        end
    end

    // Grants are forced to zero while reset is asserted, so reset takes effect in the same cycle.
    always_comb begin
        grants_o = '0;
        if (!reset_i && (credit_q != '0)) begin
            if (state_q == LOCKED) begin
                grants_o[owner_q] = requests_i[owner_q];
            end else if (scan_hit) begin
                grants_o[scan_win] = 1'b1;
            end
        end
    end

    assign fire      = |grants_o;
    assign cur_idx   = (state_q == LOCKED) ? owner_q : scan_win;
    assign tail_fire = fire && req_tail_i[cur_idx];
    assign next_ptr  = (cur_idx == LAST_IDX) ? '0 : cur_idx + 1'b1;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            credit_q <= CRED_MAX;
`ifdef ARB_CREDIT_CHECK_EN
            credit_err_o <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (tail_fire) begin
                        rr_ptr_q <= next_ptr;
                    end else if (fire) begin
                        state_q <= LOCKED;
                        owner_q <= scan_win;
                    end
                end
                LOCKED: begin
                    // Release the lock on the tail flit and pass priority to the next requester.
                    if (tail_fire) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= next_ptr;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A fire and a credit return in the same cycle cancel out. Credit returns saturate at the maximum.
            if (fire && !credit_return_i) begin
                credit_q <= credit_q - 1'b1;
            end else if (!fire && credit_return_i && (credit_q != CRED_MAX)) begin
                credit_q <= credit_q + 1'b1;
            end

`ifdef ARB_CREDIT_CHECK_EN
            if ((credit_return_i && !fire && (credit_q == CRED_MAX)) ||
                ((state_q == IDLE) && (|requests_i) && !scan_hit)) begin
                credit_err_o <= 1'b1;
            end
`endif
        end
    end

    assign locked_o       = (state_q == LOCKED);
    assign owner_o        = owner_q;
    assign credit_count_o = credit_q;

endmodule
